positaccum_4_raw_product: RTL and testbench
===========================================

// Module: positaccum_4_raw_product
// PURPOSE
//  Accumulates a stream of raw (unrounded) ES2 products into a running raw sum.
//  Sits directly downstream of the 4-stage raw product multiplier and consumes its serialized output.
//  Emits one serialized value_sum per burst (terminated by in_last).
//  The output word has the same layout as the sum operand that the multiplier accepts,
//  so it can be fed back into the multiplier or passed on to a rounding stage.
// PARAMETERS
//  none; all widths come from posit_defines (ABITS, MBITS, FBITS, SBITS_SUM, SBITS_PROD)
// PORTS
//  clk        in   1                                    clock, all logic on posedge
//  rst        in   1                                    synchronous, active-high reset
//  in_data    in   POSIT_SERIALIZED_WIDTH_PRODUCT_ES2   {sgn, scale, fraction[MBITS-1:0], inf, zero}
//  in_valid   in   1                                    in_data/in_last valid
//  in_last    in   1                                    marks final product of a burst
//  in_ready   out  1                                    block can accept a product this cycle
//  out_data   out  POSIT_SERIALIZED_WIDTH_SUM_ES2       {sgn, scale, fraction[ABITS-1:0], inf, zero}
//  out_valid  out  1                                    out_data holds the completed burst sum
//  out_ready  in   1                                    downstream accepts out_data
// BEHAVIOUR
//  Reset: state=IDLE; accumulator cleared (zero=1, inf=0, sgn=0, scale=0, fraction=0);
//    in_ready=1; out_valid=0; out_data=0. Any in-flight product is discarded.
//  Transfers: input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
//  FSM states and transitions:
//    IDLE  -> ALIGN  on input transfer; latch the product.
//             Product fraction is truncated to its top ABITS bits; the hidden 1 is restored
//             internally unless zero=1.
//    ALIGN -> ADD    compute d = acc.scale - prod.scale (signed).
//             Shift the smaller-scale magnitude right by min(|d|, ABITS+1); discard shifted-out bits.
//    ADD   -> NORM   equal signs: add magnitudes (ABITS+2 bits, carry kept).
//             Unequal signs: subtract the smaller magnitude from the larger; sign = sign of larger.
//             Equal magnitudes with opposite sign give exact zero, sgn=0.
//    NORM  -> IDLE   if !last_q.
//    NORM  -> OUT    if last_q.
//             NORM: on carry, shift right by 1 and scale+1.
//             Otherwise use posit_lzc and shift left by lz, scale-lz. Zero result sets zero=1, scale=0.
//    OUT   -> IDLE   on output transfer; the accumulator is cleared in the same cycle.
//  in_ready is 1 only in IDLE. One product is processed every 4 cycles.
//  Latency from the last input transfer to out_valid=1 is 4 cycles.
//  out_valid stays high and out_data stays stable in OUT until out_ready is sampled high.
//  Special cases:
//    Product zero=1: skips the arithmetic (acc unchanged) but still takes ALIGN/ADD/NORM cycles.
//    Product inf=1: acc.inf sets and remains set (sticky) until the burst ends.
//    Output: inf=1 forces zero=0.
//  Scale arithmetic uses SBITS_SUM+1 bits internally.
//    Without POSIT_ACCUM_SAT_EN, overflow wraps modulo 2^SBITS_SUM.
//  Reset asserted in any state takes priority and returns the block to its reset values on the next edge.
//  in_last on a zero or inf product still terminates the burst.
// CONFIGURATION
//  POSIT_ACCUM_SAT_EN
//    defined: scale is clamped to [-2^(SBITS_SUM-1), 2^(SBITS_SUM-1)-1].
//      Clamping high also sets fraction to all ones.
//      Clamping low sets zero=1.
//    undefined: scale wraps; there is no clamp logic.
// STRUCTURE
//  posit_defines package: add the value_accum typedef (sgn, scale[SBITS_SUM:0], mag[ABITS+1:0], inf, zero),
//    the accum_state_t enum {IDLE, ALIGN, ADD, NORM, OUT} and constant ACCUM_SHIFT_MAX = ABITS+1.
//    Reuse the existing value_sum and value_product typedefs.
//  Sub-module: posit_lzc (parameter WIDTH = ABITS+2)
//    combinational leading-zero count with an all-zero flag, instantiated in NORM.
// TESTING
//  1. Two products of 1.0 (scale=0, frac=0), second with in_last
//     -> out: sgn=0, scale=1, fraction=0, zero=0, inf=0.
//  2. +1.0 then -1.0 (last)
//     -> out: zero=1, sgn=0, scale=0.
//  3. scale=3 frac=0 plus scale=-40 (|d| > ABITS+1)
//     -> out: scale=3, fraction=0 (small operand fully shifted out).
//  4. 1.5 (frac MSB=1) then -1.0
//     -> out: scale=-1, fraction=0 (0.5, normalized by a left shift).
//  5. Burst of three where the second product has inf=1
//     -> out: inf=1, zero=0.
//  6. Hold out_ready=0 for 5 cycles after out_valid rises
//     -> out_data stable and in_ready=0 throughout; next burst accepted only after the output transfer.
//  7. Assert rst during ADD
//     -> next cycle: in_ready=1, out_valid=0; a following single-product burst of 2.0 outputs scale=1.
//  8. With POSIT_ACCUM_SAT_EN: accumulate scale=127 twice
//     -> out: scale=127, fraction all ones.
//     Without the macro: wrapped scale.

Source files
------------

// File: rtl/posit_defines.sv
// Shared widths and record types for the ES2 posit product/sum/accumulator datapath.
// Serialized words are {sgn, scale, fraction, inf, zero}, MSB first.
package posit_defines;

    localparam int ABITS      = 16;
    localparam int MBITS      = 24;
    localparam int FBITS      = 11;
    localparam int SBITS_SUM  = 8;
    localparam int SBITS_PROD = 8;

    localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES2 = 1 + SBITS_PROD + MBITS + 2;
    localparam int POSIT_SERIALIZED_WIDTH_SUM_ES2     = 1 + SBITS_SUM + ABITS + 2;

    localparam int ACCUM_SHIFT_MAX = ABITS + 1;

    typedef struct packed {
        logic                  sgn;
        logic [SBITS_PROD-1:0] scale;
        logic [MBITS-1:0]      fraction;
        logic                  inf;
        logic                  zero;
    } value_product;

    typedef struct packed {
        logic                 sgn;
        logic [SBITS_SUM-1:0] scale;
        logic [ABITS-1:0]     fraction;
        logic                 inf;
        logic                 zero;
    } value_sum;

    // mag = {carry, hidden, fraction}; scale carries one guard bit above SBITS_SUM
    typedef struct packed {
        logic               sgn;
        logic [SBITS_SUM:0] scale;
        logic [ABITS+1:0]   mag;
        logic               inf;
        logic               zero;
    } value_accum;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } accum_state_t;

endpackage

// File: rtl/positaccum_4_raw_product_lzc.sv
// Combinational leading-zero counter; count equals WIDTH when the input is all zero.
module posit_lzc #(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                     all_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    logic found;

    always_comb begin
        count    = CW'(WIDTH);
        found    = 1'b0;
        all_zero = ~|value;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = CW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/positaccum_4_raw_product.sv
// Raw ES2 product accumulator: one product per 4 cycles, one serialized sum per in_last burst.
// Build macro POSIT_ACCUM_SAT_EN clamps the running scale instead of letting it wrap.
module positaccum_4_raw_product
    import posit_defines::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0] in_data,
    input  logic                                          in_valid,
    input  logic                                          in_last,
    output logic                                          in_ready,
    output logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]     out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready
);
    localparam int SW  = SBITS_SUM + 1;
    localparam int DW  = SBITS_SUM + 2;
    localparam int MW  = ABITS + 2;
    localparam int SHW = $clog2(ACCUM_SHIFT_MAX + 1);
    localparam int LZW = $clog2(MW + 1);

    // state | meaning
    // IDLE  | waiting for a product, in_ready high
    // ALIGN | shift the smaller-scale operand right
    // ADD   | signed-magnitude add/subtract
    // NORM  | renormalize and write the accumulator
    // OUT   | hold the burst sum until out_ready
    accum_state_t state, state_nxt;

    value_product in_prod;
    value_accum   acc;
    value_sum     out_word;

    logic                  p_sgn, p_inf, p_zero, last_q;
    logic [SBITS_PROD-1:0] p_scale;
    logic [ABITS-1:0]      p_frac;
    logic                  unused_frac_lsb;

    logic [SW-1:0]         p_scale_x;
    logic [MW-1:0]         p_mag;
    logic                  p_skip;
    logic signed [DW-1:0]  d, d_abs;
    logic [SHW-1:0]        shamt;

    logic [SW-1:0]         scale_al;
    logic [MW-1:0]         mag_a, mag_p, sum_mag;
    logic                  sgn_a, sgn_p, sum_sgn;

    logic [LZW-1:0]        lz;
    logic                  sum_is_zero;
    logic [SW-1:0]         n_scale, n_scale_fit;
    logic [MW-1:0]         n_mag;
    logic                  n_zero;

    assign in_prod         = in_data;
    assign unused_frac_lsb = ^in_prod.fraction[MBITS-ABITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ALIGN;
            end
            ALIGN: state_nxt = ADD;
            ADD:   state_nxt = NORM;
            NORM:  state_nxt = last_q ? OUT : IDLE;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign p_scale_x = {{(SW-SBITS_PROD){p_scale[SBITS_PROD-1]}}, p_scale};
    assign p_mag     = {1'b0, ~p_zero, p_frac};
    assign p_skip    = p_zero | p_inf;
    assign d         = {acc.scale[SW-1], acc.scale} - {p_scale_x[SW-1], p_scale_x};
    assign d_abs     = d[DW-1] ? -d : d;
    assign shamt     = (d_abs > DW'(ACCUM_SHIFT_MAX)) ? SHW'(ACCUM_SHIFT_MAX) : d_abs[SHW-1:0];

    posit_lzc #(.WIDTH(MW)) u_lzc (
        .value    (sum_mag),
        .count    (lz),
        .all_zero (sum_is_zero)
    );

    always_comb begin
        if (sum_mag[MW-1]) begin
            n_mag   = sum_mag >> 1;
            n_scale = scale_al + SW'(1);
        end else begin
            // normalized magnitudes sit at bit ABITS, i.e. one leading zero
            n_mag   = sum_mag << (lz - LZW'(1));
            n_scale = scale_al + SW'(1) - SW'(lz);
        end
        // re-sign-extend from bit SBITS_SUM-1, wrapping modulo 2^SBITS_SUM
        n_scale_fit = n_scale ^ {n_scale[SW-1] ^ n_scale[SW-2], {(SW-1){1'b0}}};
        n_zero      = sum_is_zero;
`ifdef POSIT_ACCUM_SAT_EN
        if (!n_scale[SW-1] && n_scale[SW-2]) begin
            n_scale_fit = {2'b00, {(SW-2){1'b1}}};
            n_mag       = {2'b01, {ABITS{1'b1}}};
        end else if (n_scale[SW-1] && !n_scale[SW-2]) begin
            n_zero = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            acc.zero <= 1'b1;
            p_sgn    <= 1'b0;
            p_scale  <= '0;
            p_frac   <= '0;
            p_inf    <= 1'b0;
            p_zero   <= 1'b0;
            last_q   <= 1'b0;
            scale_al <= '0;
            mag_a    <= '0;
            mag_p    <= '0;
            sgn_a    <= 1'b0;
            sgn_p    <= 1'b0;
            sum_mag  <= '0;
            sum_sgn  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_sgn   <= in_prod.sgn;
                        p_scale <= in_prod.scale;
                        p_frac  <= in_prod.fraction[MBITS-1 -: ABITS];
                        p_inf   <= in_prod.inf;
                        p_zero  <= in_prod.zero;
                        last_q  <= in_last;
                    end
                end
                ALIGN: begin
                    sgn_p <= p_sgn;
                    if (acc.zero) begin
                        scale_al <= p_scale_x;
                        mag_a    <= '0;
                        mag_p    <= p_mag;
                        sgn_a    <= p_sgn;
                    end else if (!d[DW-1]) begin
                        scale_al <= acc.scale;
                        mag_a    <= acc.mag;
                        mag_p    <= p_mag >> shamt;
                        sgn_a    <= acc.sgn;
                    end else begin
                        scale_al <= p_scale_x;
                        mag_a    <= acc.mag >> shamt;
                        mag_p    <= p_mag;
                        sgn_a    <= acc.sgn;
                    end
                end
                ADD: begin
                    if (sgn_a == sgn_p) begin
                        sum_mag <= mag_a + mag_p;
                        sum_sgn <= sgn_a;
                    end else if (mag_a >= mag_p) begin
                        sum_mag <= mag_a - mag_p;
                        sum_sgn <= sgn_a;
                    end else begin
                        sum_mag <= mag_p - mag_a;
                        sum_sgn <= sgn_p;
                    end
                end
                NORM: begin
                    acc.inf <= acc.inf | p_inf;
                    if (!p_skip) begin
                        if (n_zero) begin
                            acc.sgn   <= 1'b0;
                            acc.scale <= '0;
                            acc.mag   <= '0;
                            acc.zero  <= 1'b1;
                        end else begin
                            acc.sgn   <= sum_sgn;
                            acc.scale <= n_scale_fit;
                            acc.mag   <= n_mag;
                            acc.zero  <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc      <= '0;
                        acc.zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_word.sgn      = acc.sgn;
        out_word.scale    = acc.scale[SBITS_SUM-1:0];
        out_word.fraction = acc.mag[ABITS-1:0];
        out_word.inf      = acc.inf;
        out_word.zero     = acc.zero & ~acc.inf;
    end

    assign out_data = (state == OUT) ? out_word : '0;

endmodule

// File: tb/tb_positaccum_4_raw_product.sv
// Self-checking bench for positaccum_4_raw_product: vector table of bursts plus
// hand-written latency, backpressure and mid-burst reset sequences.
module tb_positaccum_4_raw_product;
    import posit_defines::*;

    localparam int OW = POSIT_SERIALIZED_WIDTH_SUM_ES2;
    localparam int NV = 12;

    logic clk = 1'b0;
    logic rst, in_valid, in_last, in_ready, out_valid, out_ready;
    logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0] in_data;
    logic [OW-1:0] out_data;

    always #5 clk = ~clk;

    positaccum_4_raw_product dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic             sgn;
        int               scale;
        logic [ABITS-1:0] frac;
        logic             inf;
        logic             zero;
    } prod_t;

    typedef struct {
        logic                 sgn;
        logic [SBITS_SUM-1:0] scale;
        logic [ABITS-1:0]     frac;
        logic                 inf;
        logic                 zero;
        logic                 flags_only;
        int                   tag;
    } exp_t;

    typedef struct {
        int    n;
        prod_t p0, p1, p2;
        exp_t  e;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic prod_t mk(input logic s, input int sc, input logic [ABITS-1:0] f,
                                 input logic inf, input logic zero);
        prod_t p;
        p.sgn = s; p.scale = sc; p.frac = f; p.inf = inf; p.zero = zero;
        return p;
    endfunction

    function automatic exp_t ex(input logic s, input int sc, input logic [ABITS-1:0] f,
                                input logic inf, input logic zero, input logic fo, input int tag);
        exp_t e;
        e.sgn = s; e.scale = SBITS_SUM'(sc); e.frac = f; e.inf = inf; e.zero = zero;
        e.flags_only = fo; e.tag = tag;
        return e;
    endfunction

    // output scoreboard: compares each output transfer against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("out%0d_inf", mon_e.tag), 32'(out_data[1]), 32'(mon_e.inf));
                check($sformatf("out%0d_zero", mon_e.tag), 32'(out_data[0]), 32'(mon_e.zero));
                if (!mon_e.flags_only) begin
                    check($sformatf("out%0d_sgn", mon_e.tag), 32'(out_data[OW-1]), 32'(mon_e.sgn));
                    check($sformatf("out%0d_scale", mon_e.tag), 32'(out_data[OW-2 -: SBITS_SUM]), 32'(mon_e.scale));
                    check($sformatf("out%0d_frac", mon_e.tag), 32'(out_data[ABITS+1:2]), 32'(mon_e.frac));
                end
            end
        end
    end

    // called at a negedge; returns at the negedge following the input transfer
    task automatic send(input prod_t p, input logic last);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        in_data  = {p.sgn, SBITS_PROD'(p.scale), p.frac, (MBITS-ABITS)'($urandom), p.inf, p.zero};
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] held;
        int lat;
        int w;

        vecs[0]  = '{2, mk(0, 0, 16'h0000, 0, 0), mk(0, 0, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 1, 16'h0000, 0, 0, 0, 0)};
        vecs[1]  = '{2, mk(0, 0, 16'h0000, 0, 0), mk(1, 0, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 0, 16'h0000, 0, 1, 0, 1)};
        vecs[2]  = '{2, mk(0, 3, 16'h0000, 0, 0), mk(0, -40, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 3, 16'h0000, 0, 0, 0, 2)};
        vecs[3]  = '{2, mk(0, 0, 16'h8000, 0, 0), mk(1, 0, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, -1, 16'h0000, 0, 0, 0, 3)};
        vecs[4]  = '{3, mk(0, 0, 16'h0000, 0, 0), mk(0, 0, 16'h0000, 1, 0), mk(0, 0, 16'h0000, 0, 0),
                     ex(0, 0, 16'h0000, 1, 0, 1, 4)};
        vecs[5]  = '{3, mk(0, 0, 16'h0000, 0, 0), mk(0, 0, 16'h0000, 0, 0), mk(0, 0, 16'h0000, 0, 0),
                     ex(0, 1, 16'h8000, 0, 0, 0, 5)};
        vecs[6]  = '{2, mk(1, 1, 16'h0000, 0, 0), mk(0, -1, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(1, 0, 16'h8000, 0, 0, 0, 6)};
        vecs[7]  = '{1, mk(0, 0, 16'h0000, 0, 1), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 0, 16'h0000, 0, 1, 0, 7)};
        vecs[8]  = '{1, mk(0, 0, 16'h4000, 0, 0), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 0, 16'h4000, 0, 0, 0, 8)};
`ifdef POSIT_ACCUM_SAT_EN
        vecs[9]  = '{2, mk(0, 127, 16'h0000, 0, 0), mk(0, 127, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 127, 16'hFFFF, 0, 0, 0, 9)};
`else
        vecs[9]  = '{2, mk(0, 127, 16'h0000, 0, 0), mk(0, 127, 16'h0000, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, -128, 16'h0000, 0, 0, 0, 9)};
`endif
        vecs[10] = '{3, mk(1, 0, 16'h0000, 0, 0), mk(0, 50, 16'h0000, 0, 1), mk(1, 0, 16'h0000, 0, 0),
                     ex(1, 1, 16'h0000, 0, 0, 0, 10)};
        vecs[11] = '{1, mk(0, 5, 16'h0000, 1, 0), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0),
                     ex(0, 0, 16'h0000, 1, 0, 1, 11)};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            sb.push_back(vecs[i].e);
            send(vecs[i].p0, vecs[i].n == 1);
            if (vecs[i].n >= 2) send(vecs[i].p1, vecs[i].n == 2);
            if (vecs[i].n == 3) send(vecs[i].p2, 1'b1);
        end
        drain();

        // last transfer to out_valid
        sb.push_back(ex(0, 0, 16'h0000, 0, 0, 0, 20));
        send(mk(0, 0, 16'h0000, 0, 0), 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        drain();

        // backpressure: 1.0 + 0.5 held while a new product waits
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        sb.push_back(ex(0, 0, 16'h8000, 0, 0, 0, 21));
        send(mk(0, 0, 16'h0000, 0, 0), 1'b0);
        send(mk(0, -1, 16'h0000, 0, 0), 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_rise", 32'(out_valid), 32'd1);
        held     = out_data;
        in_data  = {1'b0, SBITS_PROD'(2), 16'h0000, (MBITS-ABITS)'(0), 1'b0, 1'b0};
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_stable", 32'(out_data), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        sb.push_back(ex(0, 2, 16'h0000, 0, 0, 0, 22));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_before_xfer", 32'(in_ready), 32'd0);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_accept_after_xfer", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // reset while the first product of a burst is in ADD
        send(mk(0, 0, 16'h8000, 0, 0), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        sb.push_back(ex(0, 1, 16'h0000, 0, 0, 0, 23));
        send(mk(0, 1, 16'h0000, 0, 0), 1'b1);
        drain();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
